// File: rtl/timer_irq_ctrl.sv
// Memory-mapped interval timer with TH reload, prescaler and sticky overflow interrupt.
// Optional overflow counter at +C is built when TIMER_OVF_COUNT_EN is defined.
module timer_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] ovfcnt_rd;

    logic        hit, wr_th, wr_tl, wr_tcon, wr_ovf;
    logic        tick, ovf;
    logic        unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:3]};

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_th   = wr && hit && (addr[3:2] == 2'd0);
    assign wr_tl   = wr && hit && (addr[3:2] == 2'd1);
    assign wr_tcon = wr && hit && (addr[3:2] == 2'd2);
    assign wr_ovf  = wr && hit && (addr[3:2] == 2'd3);

    assign tick = tcon_q[0] && (pcnt_q == PCNT_MAX);
    assign ovf  = tick && (tl_q == '1);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        pcnt_d = '0;

        if (tcon_q[0] && !tick) begin
            pcnt_d = pcnt_q + 16'd1;
        end

        // TL reloads from the pre-write TH, so a same-edge TH write only affects the next reload
        if (tick) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (ovf && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end

        if (wr_th) begin
            th_d = wdata;
        end
        if (wr_tl) begin
            tl_d = wdata;
        end
        if (wr_tcon) begin
            tcon_d = wdata[2:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            pcnt_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            pcnt_q <= pcnt_d;
        end
    end

`ifdef TIMER_OVF_COUNT_EN
    logic [31:0] ovfcnt_q, ovfcnt_d;

    always_comb begin
        ovfcnt_d = ovfcnt_q;
        if (wr_ovf) begin
            ovfcnt_d = '0;
        end else if (ovf) begin
            ovfcnt_d = ovfcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovfcnt_q <= '0;
        end else begin
            ovfcnt_q <= ovfcnt_d;
        end
    end

    assign ovfcnt_rd = ovfcnt_q;
`else
    logic unused_ovf;

    assign unused_ovf = wr_ovf;
    assign ovfcnt_rd  = '0;
`endif

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (addr[3:2])
                2'd0:    rdata = th_q;
                2'd1:    rdata = tl_q;
                2'd2:    rdata = {29'b0, tcon_q};
                default: rdata = ovfcnt_rd;
            endcase
        end
    end

    assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench: unit A (PRESCALE=1) at 0x4000_0000, unit B (PRESCALE=4) at 0x4000_0010.
module tb_timer_irq_ctrl;

    localparam logic [31:0] A = 32'h4000_0000;
    localparam logic [31:0] B = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    timer_irq_ctrl #(.BASE_ADDR(A), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .irqout(irq_a)
    );

    timer_irq_ctrl #(.BASE_ADDR(B), .PRESCALE(4)) u_b (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .irqout(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // one clock edge: the write commits on it, returns at the following negedge
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr    = 1'b0;
    endtask

    // no clock edge consumed; out-of-window units return 0, so OR the two buses
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        chk(tag, rdata_a | rdata_b, exp);
        rd   = 1'b0;
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] ovf_exp5, ovf_exp1, ovf_exp2;

    initial begin
`ifdef TIMER_OVF_COUNT_EN
        ovf_exp5 = 32'd5; ovf_exp1 = 32'd1; ovf_exp2 = 32'd2;
`else
        ovf_exp5 = 32'd0; ovf_exp1 = 32'd0; ovf_exp2 = 32'd0;
`endif
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        step(3);
        rd_chk("rst_th", A + 0, 32'h0);
        rd_chk("rst_tl", A + 4, 32'h0);
        rd_chk("rst_tcon", A + 8, 32'h0);
        chk("rst_irq", {31'b0, irq_a}, 32'h0);
        reset = 1'b1;
        step(1);

        bus_wr(A + 0, 32'h1234_5678);
        rd_chk("th_rb", A + 0, 32'h1234_5678);
        rd_chk("miss_rd", 32'h5000_0000, 32'h0);
        addr = A; rd = 1'b0; #1;
        chk("rd_low", rdata_a, 32'h0);

        // reload and irq timing
        bus_wr(A + 0, 32'hFFFF_FFFD);
        bus_wr(A + 4, 32'hFFFF_FFFD);
        bus_wr(A + 8, 32'h3);
        rd_chk("tl_start", A + 4, 32'hFFFF_FFFD);
        step(1); rd_chk("tl_fffe", A + 4, 32'hFFFF_FFFE);
        chk("irq_pre", {31'b0, irq_a}, 32'h0);
        step(1); rd_chk("tl_ffff", A + 4, 32'hFFFF_FFFF);
        step(1); rd_chk("tl_reload", A + 4, 32'hFFFF_FFFD);
        rd_chk("tcon_7", A + 8, 32'h7);
        chk("irq_set", {31'b0, irq_a}, 32'h1);
        step(3); rd_chk("tl_reload2", A + 4, 32'hFFFF_FFFD);

        // acknowledge, then masked overflow
        bus_wr(A + 8, 32'h1);
        chk("irq_ack", {31'b0, irq_a}, 32'h0);
        rd_chk("tl_cont", A + 4, 32'hFFFF_FFFE);
        step(2);
        rd_chk("tl_masked", A + 4, 32'hFFFF_FFFD);
        rd_chk("tcon_masked", A + 8, 32'h1);

        // collisions
        bus_wr(A + 8, 32'h3);
        step(1);
        rd_chk("tl_pre_col", A + 4, 32'hFFFF_FFFF);
        bus_wr(A + 4, 32'h10);
        rd_chk("col_tl_wr", A + 4, 32'h10);
        rd_chk("col_tl_tcon", A + 8, 32'h7);
        bus_wr(A + 4, 32'hFFFF_FFFE);
        step(1);
        bus_wr(A + 8, 32'h1);
        rd_chk("col_tcon", A + 8, 32'h1);
        chk("col_tcon_irq", {31'b0, irq_a}, 32'h0);
        rd_chk("col_tcon_tl", A + 4, 32'hFFFF_FFFD);
        step(2);
        bus_wr(A + 0, 32'h100);
        rd_chk("col_th_tl", A + 4, 32'hFFFF_FFFD);
        rd_chk("col_th_th", A + 0, 32'h100);

        // overflow counter
        bus_wr(A + 8, 32'h0);
        bus_wr(A + 4, 32'hFFFF_FFFF);
        bus_wr(A + 0, 32'hFFFF_FFFF);
        bus_wr(A + 12, 32'h0);
        rd_chk("ovf_clr", A + 12, 32'h0);
        bus_wr(A + 8, 32'h1);
        step(4);
        bus_wr(A + 8, 32'h0);
        rd_chk("ovf_5", A + 12, ovf_exp5);
        rd_chk("ovf_tl", A + 4, 32'hFFFF_FFFF);
        rd_chk("ovf_tcon", A + 8, 32'h0);
        bus_wr(A + 12, 32'h0);
        rd_chk("ovf_wclr", A + 12, 32'h0);
        bus_wr(A + 8, 32'h1);
        bus_wr(A + 12, 32'h0);
        rd_chk("ovf_clr_win", A + 12, 32'h0);
        step(1);
        rd_chk("ovf_1", A + 12, ovf_exp1);
        bus_wr(A + 8, 32'h0);
        rd_chk("ovf_2", A + 12, ovf_exp2);

        // prescaler on unit B
        bus_wr(B + 4, 32'h0);
        bus_wr(B + 8, 32'h1);
        step(3); rd_chk("ps_3", B + 4, 32'h0);
        step(1); rd_chk("ps_4", B + 4, 32'h1);
        step(16); rd_chk("ps_20", B + 4, 32'h5);
        step(1);
        bus_wr(B + 8, 32'h0);
        step(5); rd_chk("ps_hold", B + 4, 32'h5);
        bus_wr(B + 8, 32'h1);
        step(3); rd_chk("ps_re3", B + 4, 32'h5);
        step(1); rd_chk("ps_re4", B + 4, 32'h6);
        chk("irq_b", {31'b0, irq_b}, 32'h0);

        // asynchronous reset mid-count
        step(2);
        #2 reset = 1'b0;
        #1;
        rd_chk("arst_tl", B + 4, 32'h0);
        rd_chk("arst_tcon", B + 8, 32'h0);
        rd_chk("arst_th_a", A + 0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(8);
        rd_chk("arst_idle", B + 4, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
